// File: rtl/argmax_pkg.sv
// Shared types and helpers for the sequential max/argmax scan controller.
package argmax_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Default geometry of the NN output buffer.
  localparam int DefElementSize  = 32;
  localparam int DefElementCount = 10;
  localparam int DefAddrW        = 4;
  localparam int DefLenW         = 5;

  // Number of bits needed to encode 'value' distinct codes (0..value-1).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/argmax_scan_ctrl_if.sv
// Start/length request, synchronous buffer read port and result bus of the scan controller.
interface argmax_scan_ctrl_if #(
  parameter int ELEMENT_SIZE = 32,
  parameter int ADDR_W       = 4,
  parameter int LEN_W        = 5
);

  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ELEMENT_SIZE-1:0] rd_data;
  logic                    busy;
  logic                    done;
  logic [ELEMENT_SIZE-1:0] max_value;
  logic [ADDR_W-1:0]       max_index;

  // The controller masters the buffer read port and owns the result bus.
  modport master (
    input  start, len, rd_data,
    output rd_en, rd_addr, busy, done, max_value, max_index
  );

  // The surrounding logic requests scans and serves the buffer reads.
  modport slave (
    output start, len, rd_data,
    input  rd_en, rd_addr, busy, done, max_value, max_index
  );

endinterface

// File: rtl/argmax_update.sv
// One shared comparator: decides whether the freshly read element replaces the running maximum.
module argmax_update #(
  parameter int ELEMENT_SIZE = 32,
  parameter int ADDR_W       = 4
) (
  input  logic                    first_i,
  input  logic [ELEMENT_SIZE-1:0] runValue_i,
  input  logic [ADDR_W-1:0]       runIndex_i,
  input  logic [ELEMENT_SIZE-1:0] newValue_i,
  input  logic [ADDR_W-1:0]       newIndex_i,
  output logic [ELEMENT_SIZE-1:0] selValue_o,
  output logic [ADDR_W-1:0]       selIndex_o
);

  // Strictly-greater unsigned compare so ties keep the earlier (lower) index; the first element always loads.
  always_comb begin
    selValue_o = runValue_i;
    selIndex_o = runIndex_i;
    if (first_i || (newValue_i > runValue_i)) begin
      selValue_o = newValue_i;
      selIndex_o = newIndex_i;
    end
  end

endmodule

// File: rtl/argmax_scan_ctrl.sv
// Sequential max/argmax over a stored activation buffer, one element per cycle through a 1-cycle read port.
module argmax_scan_ctrl
  import argmax_pkg::*;
#(
  parameter int ELEMENT_SIZE  = DefElementSize,
  parameter int ELEMENT_COUNT = DefElementCount,
  parameter int ADDR_W        = DefAddrW,
  parameter int LEN_W         = DefLenW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  argmax_scan_ctrl_if.master  bus
);

  if (ADDR_W < clog2(ELEMENT_COUNT)) begin : gAddrWidthCheck
    $error("argmax_scan_ctrl: ADDR_W too narrow for ELEMENT_COUNT");
  end
  if (LEN_W < clog2(ELEMENT_COUNT + 1)) begin : gLenWidthCheck
    $error("argmax_scan_ctrl: LEN_W cannot hold ELEMENT_COUNT");
  end

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       lastAddr_q;
  logic                    rdValid_q;
  logic [ADDR_W-1:0]       rdIndex_q;
  logic [ELEMENT_SIZE-1:0] runValue_q;
  logic [ADDR_W-1:0]       runIndex_q;
  logic [ELEMENT_SIZE-1:0] maxValue_q;
  logic [ADDR_W-1:0]       maxIndex_q;

  logic [LEN_W-1:0]        lenEff;
  logic                    startAccept;
  logic                    lastIssue;
  logic [ELEMENT_SIZE-1:0] selValue;
  logic [ADDR_W-1:0]       selIndex;

  assign lenEff      = (bus.len > LEN_W'(ELEMENT_COUNT)) ? LEN_W'(ELEMENT_COUNT) : bus.len;
  assign startAccept = (state_q == IDLE) && bus.start;
  assign lastIssue   = (addr_q == lastAddr_q);

  assign bus.rd_en     = (state_q == ISSUE);
  assign bus.rd_addr   = addr_q;
  assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done      = (state_q == FINISH);
  assign bus.max_value = maxValue_q;
  assign bus.max_index = maxIndex_q;

  argmax_update #(
    .ELEMENT_SIZE(ELEMENT_SIZE),
    .ADDR_W      (ADDR_W)
  ) u_update (
    .first_i   (rdIndex_q == '0),
    .runValue_i(runValue_q),
    .runIndex_i(runIndex_q),
    .newValue_i(bus.rd_data),
    .newIndex_i(rdIndex_q),
    .selValue_o(selValue),
    .selIndex_o(selIndex)
  );

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: issue L reads, one drain cycle for the last read's data, then a single done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (lenEff == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (lastIssue) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address counter, read-data tracking, running maximum and published result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      lastAddr_q <= '0;
      rdValid_q  <= 1'b0;
      rdIndex_q  <= '0;
      runValue_q <= '0;
      runIndex_q <= '0;
      maxValue_q <= '0;
      maxIndex_q <= '0;
    end else begin
      rdValid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rdIndex_q <= addr_q;
      end
      if (startAccept) begin
        addr_q     <= '0;
        lastAddr_q <= ADDR_W'(lenEff - LEN_W'(1));
        if (lenEff == '0) begin
          maxValue_q <= '0;
          maxIndex_q <= '0;
        end
      end else if ((state_q == ISSUE) && !lastIssue) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (rdValid_q) begin
        runValue_q <= selValue;
        runIndex_q <= selIndex;
      end
      if (state_q == DRAIN) begin
        maxValue_q <= selValue;
        maxIndex_q <= selIndex;
      end
    end
  end

endmodule

// File: doc/argmax_scan_ctrl.md
Name: argmax_scan_ctrl

Overview:
Sequential max/argmax controller for the NN output stage. On `start` it walks a stored activation buffer element by element through a synchronous read port. It keeps a running maximum and its index, then reports the winning value and index with a one-cycle `done` pulse. It replaces a wide, fully parallel largest-element compare with one comparator, time-shared over ELEMENT_COUNT cycles.

Parameters:
- ELEMENT_SIZE, 32, bit width of one element; compare is unsigned.
- ELEMENT_COUNT, 10, buffer depth; maximum scan length.
- ADDR_W, 4, address/index width; must satisfy 2^ADDR_W >= ELEMENT_COUNT.
- LEN_W, 5, width of `len`; must hold ELEMENT_COUNT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- len  in  LEN_W  number of elements to scan; sampled with `start`.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  ELEMENT_SIZE  buffer data, valid the cycle after rd_en/rd_addr.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; result valid.
- max_value  out  ELEMENT_SIZE  largest element of the last completed scan.
- max_index  out  ADDR_W  index of that element.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; rd_en, busy, done = 0.
  - rd_addr, max_value, max_index = 0.
  - Internal running registers = 0.
  - Reset has priority over everything, including mid-scan: the scan is aborted with no `done` and outputs cleared.
- States:
  - IDLE: busy=0; wait for start=1.
  - ISSUE: rd_en=1; rd_addr counts 0..L-1, one address per cycle.
  - DRAIN: rd_en=0; absorbs the last read's data.
  - FINISH: done=1 for exactly one cycle, then back to IDLE.
- Timing (start sampled in cycle 0, L = effective length, 1 <= L <= ELEMENT_COUNT):
  - rd_en high in cycles 1..L, with rd_addr = cycle-1.
  - busy high in cycles 1..L+1.
  - done high in cycle L+2; max_value/max_index update at the same edge that raises done.
- Compare rule (data for address k is seen in cycle k+2):
  - k=0 loads the running value and index unconditionally.
  - For k>0, the running registers are replaced only if rd_data > running value (strict).
  - Ties therefore keep the lowest index.
- Output stability: max_value/max_index hold the previous result throughout a scan and change only at done.
- len=0: no reads; done in cycle 1; max_value=0, max_index=0.
- len>ELEMENT_COUNT: clamped to ELEMENT_COUNT.
- start while busy, or during the FINISH cycle: ignored.
- start=1 in the cycle after done (IDLE): accepted, so back-to-back scans are possible.
- `len` is sampled only at accepted start; later changes have no effect on the running scan.
- rd_addr holds its last value when rd_en=0.

Decomposition:
- Package argmax_pkg:
  - state encoding (IDLE, ISSUE, DRAIN, FINISH);
  - clog2 constant function used to derive ADDR_W/LEN_W checks.
- One sub-module, argmax_update: combinational compare/select of (running value, running index) against (rd_data, current index), with a `first` input forcing the load.
- FSM, address counter and registers stay in argmax_scan_ctrl.
- Buffer model (synchronous 1-cycle read) lives in the bench only.

Test Plan:
- Basic scan: buffer[0..9] = 87,45,66,29,133,42,16,100,187,53; len=10 -> done in cycle 12, max_value=187, max_index=8; rd_en high exactly cycles 1..10.
- Second vector and back-to-back: buffer[0..9] = 897,4995,2663,2669,1373,4222,146,10340,13487,3453; scan twice, second start the cycle after the first done -> 13487/8 both times, the second done exactly 12 cycles after its start.
- Edge indices:
  - ascending 0..9 -> 9/9;
  - buffer[0]=32'hFFFFFFFF, rest 1 -> FFFFFFFF/0 (unsigned compare);
  - all elements 5 -> 5/0 (tie keeps lowest index).
- Length handling:
  - len=3 on the basic vector -> 87/0, done in cycle 5;
  - len=0 -> done in cycle 1, 0/0, no rd_en;
  - len=15 -> behaves as len=10.
- Ignored/changed inputs: during a scan, pulse start and change len -> no restart, result unchanged from the basic scan, max outputs hold the old result until done.
- Reset mid-scan: rst=1 at cycle 4 of a scan -> next cycle busy=0, rd_en=0, outputs 0, no done; a fresh scan afterwards returns the correct result.
